bin_to_bcd_seq: RTL

//   Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).

---
 rtl/bin_to_bcd_seq_if.sv | 22 ++
 rtl/bin_to_bcd_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the binary source, the BCD converter and the display scanner.
interface bin_to_bcd_seq_if #(
    parameter int unsigned IN_W   = 14,
    parameter int unsigned DIGITS = 4
);
    logic [IN_W-1:0]     in_bin;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd;
    logic                ovf;
    logic                done;

    modport master (
        output in_bin, in_valid,
        input  in_ready, bcd, ovf, done
    );

    modport slave (
        input  in_bin, in_valid,
        output in_ready, bcd, ovf, done
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Inputs above 10^DIGITS-1 saturate to all nines and raise ovf.
module bin_to_bcd_seq #(
    parameter int unsigned IN_W   = 14,
    parameter int unsigned DIGITS = 4
) (
    input logic             clk,
    input logic             rst_n,
    bin_to_bcd_seq_if.slave bus
);
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(IN_W + 1);

    function automatic logic [63:0] all_nines(input int unsigned d);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < d; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAXV = all_nines(DIGITS);

    typedef enum logic {IDLE, CONV} state_t;

    state_t          state, state_nxt;
    logic [IN_W-1:0] shift_q;
    logic [BW-1:0]   scratch_q;
    logic [BW-1:0]   adj;
    logic [BW-1:0]   scratch_nxt;
    logic [CW-1:0]   cnt_q;
    logic            ovf_pend_q;
    logic [BW-1:0]   bcd_q;
    logic            ovf_q;
    logic            done_q;
    logic            accept;
    logic            last;
    logic            clamp;

    assign accept = (state == IDLE) && bus.in_valid;
    assign last   = (state == CONV) && (cnt_q == CW'(1));
    assign clamp  = 64'(bus.in_bin) > MAXV;

    // Add-3 correction on every digit, then shift in the next input MSB.
    always_comb begin
        adj = scratch_q;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
        end
        scratch_nxt = (adj << 1) | BW'(shift_q[IN_W-1]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) state_nxt = CONV;
            CONV: if (cnt_q == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                shift_q    <= clamp ? IN_W'(MAXV) : bus.in_bin;
                ovf_pend_q <= clamp;
                scratch_q  <= '0;
                cnt_q      <= CW'(IN_W);
            end else if (state == CONV) begin
                shift_q   <= shift_q << 1;
                scratch_q <= scratch_nxt;
                cnt_q     <= cnt_q - CW'(1);
                if (last) begin
                    bcd_q  <= scratch_nxt;
                    ovf_q  <= ovf_pend_q;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.bcd      = bcd_q;
    assign bus.ovf      = ovf_q;
    assign bus.done     = done_q;
endmodule
